// File: rtl/approx_mac_pkg.sv
// Shared types and default widths for the approximate-multiplier MAC accumulator.
package approx_mac_pkg;

  localparam int unsigned ACC_W_DEFAULT = 24;
  localparam int unsigned LEN_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_e;

endpackage

// File: rtl/approx_err_unit.sv
// Exact 8x8 product and its absolute distance from the approximate product.
module approx_err_unit (
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  input  logic [15:0] z_approx,
  output logic [15:0] err
);

  logic [15:0] exact;

  always_comb begin
    exact = 16'(x) * 16'(y);
    err   = (exact >= z_approx) ? (exact - z_approx) : (z_approx - exact);
  end

endmodule

// File: rtl/approx_mac_accum.sv
// Burst accumulator of approximate products with a handshaked result.
// Define APPROX_ERR_MON_EN to add the err_sum/err_max error monitor.
module approx_mac_accum
  import approx_mac_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEFAULT,
  parameter int unsigned LEN_W = LEN_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       x,
  input  logic [7:0]       y,
  input  logic [15:0]      z_approx,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready
`ifdef APPROX_ERR_MON_EN
  ,
  output logic [ACC_W-1:0] err_sum,
  output logic [15:0]      err_max
`endif
);

  state_e           state_q;
  logic [LEN_W-1:0] cnt_q;
  logic [ACC_W-1:0] acc_q;
  logic             in_ready_q;
  logic             out_valid_q;

`ifdef APPROX_ERR_MON_EN
  logic [15:0]      err;
  logic [ACC_W-1:0] err_sum_q;
  logic [15:0]      err_max_q;

  approx_err_unit u_err (
    .x        (x),
    .y        (y),
    .z_approx (z_approx),
    .err      (err)
  );

  assign err_sum = err_sum_q;
  assign err_max = err_max_q;
`else
  // Operands only feed the error monitor.
  logic unused_xy;
  assign unused_xy = ^{x, y};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef APPROX_ERR_MON_EN
      err_sum_q   <= '0;
      err_max_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q <= '0;
`ifdef APPROX_ERR_MON_EN
            err_sum_q <= '0;
            err_max_q <= '0;
`endif
            if (len != '0) begin
              cnt_q      <= len;
              state_q    <= ACC;
              in_ready_q <= 1'b1;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        ACC: begin
          if (in_valid && in_ready_q) begin
            acc_q <= acc_q + ACC_W'(z_approx);
            cnt_q <= cnt_q - LEN_W'(1);
`ifdef APPROX_ERR_MON_EN
            err_sum_q <= err_sum_q + ACC_W'(err);
            if (err > err_max_q) err_max_q <= err;
`endif
            if (cnt_q == LEN_W'(1)) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign acc_out   = acc_q;

endmodule

// File: tb/tb_approx_mac_accum.sv
// Directed-plus-random bench for approx_mac_accum; honours APPROX_ERR_MON_EN.
module tb_approx_mac_accum;

  localparam int ACC_W = 24;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic [7:0]       x, y;
  logic [15:0]      z_approx;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] acc_out;
  logic             out_valid;
  logic             out_ready;
`ifdef APPROX_ERR_MON_EN
  logic [ACC_W-1:0] err_sum;
  logic [15:0]      err_max;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state: plain integer sums over accepted beats.
  longint exp_acc;
  longint exp_esum;
  int     exp_emax;

  // Optional fixed beats; when empty, beats are random.
  int qx[$];
  int qy[$];
  int qz[$];
  int zfix = -1;

  always #5 clk = ~clk;

  approx_mac_accum #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .x         (x),
    .y         (y),
    .z_approx  (z_approx),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .acc_out   (acc_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef APPROX_ERR_MON_EN
    ,
    .err_sum   (err_sum),
    .err_max   (err_max)
`endif
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_result();
    chk("acc_out", acc_out, exp_acc % (64'd1 << ACC_W));
`ifdef APPROX_ERR_MON_EN
    chk("err_sum", err_sum, exp_esum % (64'd1 << ACC_W));
    chk("err_max", err_max, exp_emax);
`endif
  endtask

  task automatic begin_burst(input int n);
    start = 1'b1;
    len   = LEN_W'(n);
    step();
    start    = 1'b0;
    exp_acc  = 0;
    exp_esum = 0;
    exp_emax = 0;
  endtask

  // Feed n beats (random in_valid stalls if stall=1); checks timing of out_valid.
  task automatic feed(input int n, input bit stall);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 4000) begin
      guard++;
      in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (qz.size() > 0) begin
        x = 8'(qx.pop_front()); y = 8'(qy.pop_front()); z_approx = 16'(qz.pop_front());
      end else begin
        x = 8'($urandom); y = 8'($urandom);
        z_approx = (zfix >= 0) ? 16'(zfix) : 16'($urandom);
      end
      chk("in_ready_acc", in_ready, 1);
      step();
      if (in_valid) begin
        int e;
        e = int'(x) * int'(y) - int'(z_approx);
        if (e < 0) e = -e;
        exp_acc  += z_approx;
        exp_esum += e;
        if (e > exp_emax) exp_emax = e;
        i++;
      end
      if (i < n) chk("out_valid_early", out_valid, 0);
    end
    in_valid = 1'b0;
    chk("beats_done", i, n);
    chk("out_valid_done", out_valid, 1);
    chk("in_ready_done", in_ready, 0);
    chk_result();
  endtask

  // Hold out_ready low for `hold` cycles (pulsing start), then accept.
  task automatic drain(input int hold);
    out_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      start = 1'b1;
      len   = LEN_W'(1);
      step();
      chk("out_valid_hold", out_valid, 1);
      chk("in_ready_hold", in_ready, 0);
      chk_result();
    end
    start     = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("out_valid_idle", out_valid, 0);
    chk("in_ready_idle", in_ready, 0);
    step();
    chk("still_idle", out_valid | in_ready, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; x = '0; y = '0; z_approx = '0;
    in_valid = 1'b0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_acc", acc_out, 0);
`ifdef APPROX_ERR_MON_EN
    chk("rst_err_sum", err_sum, 0);
    chk("rst_err_max", err_max, 0);
`endif

    // Scenario 1: 100 + 200 + 300.
    qx = '{1, 2, 3}; qy = '{1, 2, 3}; qz = '{100, 200, 300};
    begin_burst(3);
    feed(3, 1'b0);
    chk("s1_acc", acc_out, 600);
    drain(0);

    // Scenario 2: zero-length burst completes immediately.
    begin_burst(0);
    chk("s2_out_valid", out_valid, 1);
    chk("s2_in_ready", in_ready, 0);
    chk_result();
    drain(1);

    // Scenario 3: 255 beats of 0xFFFF.
    zfix = 16'hFFFF;
    begin_burst(255);
    feed(255, 1'b0);
    chk("s3_acc", acc_out, 32'hFEFF01);
    drain(0);
    zfix = -1;

    // Scenario 4: reset mid-burst takes priority over start and handshakes.
    begin_burst(4);
    in_valid = 1'b1; z_approx = 16'd50; step(); step();
    rst = 1'b1; start = 1'b1; len = LEN_W'(2); out_ready = 1'b1;
    step();
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("s4_in_ready", in_ready, 0);
    chk("s4_out_valid", out_valid, 0);
    chk("s4_acc", acc_out, 0);
`ifdef APPROX_ERR_MON_EN
    chk("s4_err_sum", err_sum, 0);
    chk("s4_err_max", err_max, 0);
`endif
    qx = '{0}; qy = '{0}; qz = '{7};
    begin_burst(1);
    feed(1, 1'b0);
    chk("s4_acc7", acc_out, 7);
    drain(0);

    // Scenario 5: random burst with input stalls, output stalled 5 cycles.
    begin_burst(6);
    feed(6, 1'b1);
    drain(5);

    // Scenario 6: error statistics 15 and 25.
    qx = '{3, 255}; qy = '{5, 255}; qz = '{0, 65000};
    begin_burst(2);
    feed(2, 1'b0);
    chk("s6_acc", acc_out, 65000);
`ifdef APPROX_ERR_MON_EN
    chk("s6_err_sum", err_sum, 40);
    chk("s6_err_max", err_max, 25);
`endif
    drain(2);

    // Random bursts with stalls.
    for (int b = 0; b < 6; b++) begin
      int n;
      n = $urandom_range(1, 20);
      begin_burst(n);
      feed(n, 1'b1);
      drain($urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/approx_mac_accum.md
APPROX_MAC_ACCUM -- requirements
Module: approx_mac_accum

Interface
REQ-001 The module SHALL take parameter ACC_W, default 24, as the accumulator and error-sum width in bits (minimum 16).
REQ-002 The module SHALL take parameter LEN_W, default 8, as the beat-count width in bits.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  single-cycle request to begin a burst; sampled only in IDLE.
REQ-006 len  input  LEN_W  number of products in the burst; latched when start is accepted.
REQ-007 x, y  input  8 each  operand pair presented to the upstream approximate 8x8 multiplier in the same beat.
REQ-008 z_approx  input  16  product from the upstream approximate multiplier for the current x, y.
REQ-009 in_valid / in_ready  input / output  1 each  beat handshake for x, y and z_approx.
REQ-010 acc_out  output  ACC_W  accumulated sum of the burst.
REQ-011 out_valid / out_ready  output / input  1 each  result handshake.
REQ-012 err_sum  output  ACC_W  and err_max  output  16  error statistics (present only with the macro in REQ-030).

Function
REQ-013 The state machine SHALL have exactly three states: IDLE, ACC and DONE.
REQ-014 IDLE with start=1 and len!=0: latch len into the beat counter, clear acc and the statistics, go to ACC.
REQ-015 IDLE with start=1 and len=0: clear acc, go directly to DONE with acc_out=0.
REQ-016 in_ready SHALL be 1 only in ACC; a beat is accepted when in_valid and in_ready are both 1.
REQ-017 Each accepted beat SHALL add z_approx, zero-extended to ACC_W, to acc; the sum wraps modulo 2^ACC_W. ACC_W=24 never wraps for 255 beats.
REQ-018 Each accepted beat SHALL decrement the counter; the beat that takes the counter from 1 to 0 SHALL move the block to DONE on the next edge.
REQ-019 out_valid SHALL be 1 exactly in DONE, starting the cycle after the last beat is accepted (one-cycle latency).
REQ-020 While out_valid=1, acc_out and the statistics SHALL hold stable.
REQ-021 DONE with out_ready=1 SHALL return the block to IDLE on the next edge.
REQ-022 start asserted outside IDLE SHALL be ignored.
REQ-023 in_valid stalls in ACC SHALL hold all state unchanged.
REQ-024 out_ready stalls in DONE SHALL hold all state unchanged.
REQ-025 x and y SHALL be used only by the error monitor; accumulation uses z_approx alone.

Reset
REQ-026 rst=1 at any clock edge, including mid-burst or in DONE, SHALL force IDLE.
REQ-027 rst=1 SHALL clear acc, the counter, err_sum and err_max.
REQ-028 rst=1 SHALL drive in_ready=0 and out_valid=0 in the following cycle; rst SHALL take priority over start and both handshakes.
REQ-029 After reset, acc_out SHALL read 0.

Configuration
REQ-030 Macro APPROX_ERR_MON_EN defined: per accepted beat, compute the exact product x*y (16 bits) and the error e = |x*y - z_approx|.
REQ-031 Macro APPROX_ERR_MON_EN defined: err_sum += e (zero-extended, wraps modulo 2^ACC_W), and err_max = max(err_max, e).
REQ-032 Macro APPROX_ERR_MON_EN undefined: the err_sum and err_max ports, the exact multiplier and the statistics registers SHALL be absent; all other behaviour is identical.

Structure
REQ-033 Package approx_mac_pkg SHALL hold the state enum (IDLE, ACC, DONE) and the default ACC_W and LEN_W constants.
REQ-034 The exact-product and absolute-error datapath SHALL be one sub-module, approx_err_unit, instantiated only under APPROX_ERR_MON_EN.

Verification
REQ-035 Scenario 1: len=3, beats z=100, 200, 300, out_ready=1 -> out_valid exactly one cycle after the third beat, acc_out=600, then IDLE.
REQ-036 Scenario 2: len=0 -> out_valid the next cycle, acc_out=0, in_ready never asserted.
REQ-037 Scenario 3: len=255, every z=0xFFFF -> acc_out=16,711,425 (0xFEFF01), no wrap at ACC_W=24.
REQ-038 Scenario 4: rst pulse after 2 of 4 beats -> IDLE, acc_out=0, out_valid=0; a new len=1, z=7 burst then yields 7.
REQ-039 Scenario 5: out_ready=0 for 5 cycles in DONE, with start pulsed -> acc_out held, start ignored, IDLE only after out_ready=1.
REQ-040 Scenario 6 (APPROX_ERR_MON_EN): beats (x=3, y=5, z=0) and (x=255, y=255, z=65000) -> err_sum=40, err_max=25.
